// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through no-write-allocate data cache controller
// Owns the single data_memory port; fills take one cycle from the full-block bus.
module dcache_ctrl #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 16,
  parameter int LINES      = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_we,
  input  logic [WORD_SIZE-1:0]            req_addr,
  input  logic [WORD_SIZE-1:0]            req_wdata,
  input  logic                            flush,
  output logic                            resp_valid,
  output logic [WORD_SIZE-1:0]            resp_rdata,
  output logic [WORD_SIZE-1:0]            mem_ptr,
  output logic [WORD_SIZE-1:0]            mem_val,
  output logic                            mem_we,
  input  logic [BLOCK_SIZE*WORD_SIZE-1:0] mem_block,
  output logic [15:0]                     hit_count,
  output logic [15:0]                     miss_count
);

  localparam int OFF_W = $clog2(BLOCK_SIZE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = WORD_SIZE - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, WRITE} state_t;

  state_t state, state_nxt;

  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic                 we_q;
  logic [LINES-1:0]     valid_q;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [WORD_SIZE-1:0] data_q [LINES][BLOCK_SIZE];
  logic [WORD_SIZE-1:0] fill_word [BLOCK_SIZE];

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] line_tag;
  logic             hit;

  assign off      = addr_q[OFF_W-1:0];
  assign idx      = addr_q[OFF_W +: IDX_W];
  assign line_tag = addr_q[WORD_SIZE-1 -: TAG_W];
  assign hit      = valid_q[idx] && (tag_q[idx] == line_tag);

  // Word 0 of a line sits in the MSBs of the block bus.
  always_comb begin
    for (int k = 0; k < BLOCK_SIZE; k++) begin
      fill_word[k] = mem_block[(BLOCK_SIZE-k)*WORD_SIZE-1 -: WORD_SIZE];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!flush && req_valid) state_nxt = LOOKUP;
      LOOKUP:  begin
        if (we_q)     state_nxt = WRITE;
        else if (hit) state_nxt = IDLE;
        else          state_nxt = FILL;
      end
      FILL:    state_nxt = IDLE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    mem_ptr   = '0;
    mem_val   = '0;
    mem_we    = 1'b0;
    case (state)
      IDLE:  req_ready = !flush;
      FILL:  mem_ptr   = addr_q;
      WRITE: begin
        mem_ptr = addr_q;
        mem_val = wdata_q;
        mem_we  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      valid_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            valid_q <= '0;
          end else if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            we_q    <= req_we;
          end
        end
        LOOKUP: begin
          if (!we_q) begin
            if (hit) begin
              resp_rdata <= data_q[idx][off];
              resp_valid <= 1'b1;
              if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end else begin
              if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
          end
        end
        FILL: begin
          valid_q[idx] <= 1'b1;
          resp_rdata   <= fill_word[off];
          resp_valid   <= 1'b1;
        end
        WRITE: resp_valid <= 1'b1;
        default: ;
      endcase
    end
  end

  // Tag/data storage needs no reset: valid_q gates every use.
  always_ff @(posedge clk) begin
    if (state == FILL) begin
      tag_q[idx] <= line_tag;
      for (int k = 0; k < BLOCK_SIZE; k++) begin
        data_q[idx][k] <= fill_word[k];
      end
    end else if (state == WRITE && hit) begin
      data_q[idx][off] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - scoreboard bench for dcache_ctrl against a behavioural cache model
// Memory image is modelled here; expectations come from a separate reference image.
module tb_dcache_ctrl;

  localparam int W = 32;
  localparam int B = 16;
  localparam int L = 8;
  localparam int MEMW = 1024;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req_valid, req_ready, req_we, flush;
  logic [W-1:0]   req_addr, req_wdata;
  logic           resp_valid;
  logic [W-1:0]   resp_rdata, mem_ptr, mem_val;
  logic           mem_we;
  logic [B*W-1:0] mem_block;
  logic [15:0]    hit_count, miss_count;

  always #5 clk = ~clk;

  dcache_ctrl #(.WORD_SIZE(W), .BLOCK_SIZE(B), .LINES(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_ptr(mem_ptr), .mem_val(mem_val), .mem_we(mem_we), .mem_block(mem_block),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  logic [W-1:0] mem     [MEMW];
  logic [W-1:0] ref_mem [MEMW];

  always_comb begin
    mem_block = '0;
    for (int k = 0; k < B; k++) begin
      mem_block[(B-k)*W-1 -: W] = mem[(int'(mem_ptr[9:4]) << 4) + k];
    end
  end

  always @(posedge clk) if (mem_we) mem[mem_ptr[9:0]] <= mem_val;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        is_load;
    logic [31:0] rdata;
    int          lat;
    int          cyc0;
    logic [15:0] hits;
    logic [15:0] misses;
  } exp_t;

  exp_t sb[$];

  logic        ref_valid [L];
  int          ref_tag   [L];
  logic [15:0] ref_hits, ref_misses;

  task automatic model_clear();
    for (int i = 0; i < L; i++) ref_valid[i] = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && resp_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("latency", 32'(cyc - e.cyc0), 32'(e.lat));
        if (e.is_load) check("rdata", resp_rdata, e.rdata);
        check("hit_count", 32'(hit_count), 32'(e.hits));
        check("miss_count", 32'(miss_count), 32'(e.misses));
        check("ready_in_resp", 32'(req_ready), 32'd1);
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int   n = 0;
    int   li, tg;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    #1;
    while (!req_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!req_ready) begin
      check("ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    li = int'(addr >> 4) % L;
    tg = int'(addr >> 7);
    e.cyc0 = cyc;
    e.is_load = !we;
    e.rdata = '0;
    if (we) begin
      ref_mem[addr[9:0]] = wdata;
      e.lat = 3;
    end else begin
      if (ref_valid[li] && ref_tag[li] == tg) begin
        if (ref_hits != 16'hFFFF) ref_hits++;
        e.lat = 2;
      end else begin
        if (ref_misses != 16'hFFFF) ref_misses++;
        e.lat = 3;
        ref_valid[li] = 1'b1;
        ref_tag[li] = tg;
      end
      e.rdata = ref_mem[addr[9:0]];
    end
    e.hits = ref_hits;
    e.misses = ref_misses;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic flush_cache();
    drain();
    @(negedge clk);
    flush = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = '0;
    #1 check("flush_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    req_valid = 1'b0;
    model_clear();
  endtask

  initial begin
    int bad_words;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; flush = 1'b0;
    for (int i = 0; i < MEMW; i++) mem[i] = $urandom;
    for (int k = 0; k < B; k++) mem[32'h80 + k] = 32'(k);
    for (int i = 0; i < MEMW; i++) ref_mem[i] = mem[i];
    model_clear();
    ref_hits = '0;
    ref_misses = '0;

    repeat (3) @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_miss_count", 32'(miss_count), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_ptr", mem_ptr, 32'd0);
    check("rst_mem_val", mem_val, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;

    issue(1'b0, 32'h05, '0);
    issue(1'b0, 32'h0A, '0);
    issue(1'b1, 32'h05, 32'hDEADBEEF);
    issue(1'b0, 32'h05, '0);
    drain();
    check("mem_05", mem[32'h05], 32'hDEADBEEF);
    issue(1'b1, 32'h123, 32'h1234_5678);
    drain();
    check("mem_123", mem[32'h123], 32'h1234_5678);
    issue(1'b0, 32'h123, '0);
    issue(1'b0, 32'h00, '0);
    issue(1'b0, 32'h80, '0);
    issue(1'b0, 32'h00, '0);
    issue(1'b0, 32'h87, '0);
    issue(1'b0, 32'h8F, '0);
    issue(1'b0, 32'h00, '0);
    flush_cache();
    issue(1'b0, 32'h00, '0);

    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) flush_cache();
      else issue(r < 7, (32'($urandom_range(0, 3)) << 7) | 32'($urandom_range(0, 127)), $urandom);
    end

    drain();
    issue(1'b0, 32'h00, '0);
    drain();
    @(negedge clk);
    force dut.hit_count = 16'hFFFD;
    @(posedge clk);
    #1 release dut.hit_count;
    ref_hits = 16'hFFFD;
    check("forced_hits", 32'(hit_count), 32'hFFFD);
    for (int n = 0; n < 4; n++) issue(1'b0, 32'(n), '0);
    drain();

    flush_cache();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h345;
    #1 check("rt_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 check("fill_ptr", mem_ptr, 32'h345);
    rst_n = 1'b0;
    #1;
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_resp_rdata", resp_rdata, 32'd0);
    check("mid_rst_hit_count", 32'(hit_count), 32'd0);
    check("mid_rst_miss_count", 32'(miss_count), 32'd0);
    check("mid_rst_mem_ptr", mem_ptr, 32'd0);
    check("mid_rst_mem_we", 32'(mem_we), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    ref_hits = '0;
    ref_misses = '0;
    issue(1'b0, 32'h345, '0);
    issue(1'b0, 32'h346, '0);
    drain();

    bad_words = 0;
    for (int i = 0; i < MEMW; i++) if (mem[i] !== ref_mem[i]) bad_words++;
    check("mem_image", 32'(bad_words), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
